pass_request_conditioner: RTL and testbench
===========================================

// Module: pass_request_conditioner
// PURPOSE
//  Upstream stage of the traffic light controller. Conditions the raw pedestrian button into the
//  controller's pass input as a clean one-cycle request: synchronise, debounce, suppress while
//  green, enforce a cooldown between requests. Output pass drives the controller's pass port directly.
// PARAMETERS
//  DEBOUNCE_CYCLES  16    consecutive synchronised-high cycles required to accept a press (>=1)
//  COOLDOWN_CYCLES  2048  cycles after release during which new presses are not accepted (>=1)
//  CNT_W            12    width of the shared phase counter; must hold max(DEBOUNCE,COOLDOWN)
// PORTS
//  clk          in   1  clock (same clock as the controller)
//  rst          in   1  synchronous, active-high reset
//  btn_raw      in   1  asynchronous raw pedestrian button, bouncy
//  green_in     in   1  controller G output; press is absorbed when 1
//  pass         out  1  registered one-cycle pass request to the controller
//  busy         out  1  1 whenever FSM is not IDLE
//  pass_count   out  8  number of pass pulses emitted, wraps 255->0
// BEHAVIOUR
//  - Reset: one clk, synchronous, active-high; rst=1 -> state IDLE, cnt=0, sync flops=0, pass=0,
//    busy=0, pass_count=0, pending=0. Reset mid-operation aborts any phase; no pass pulse is emitted.
//  - btn_raw -> 2-flop synchroniser -> sync. All FSM decisions use sync only.
//  - FSM states: IDLE, DEBOUNCE, HELD, COOLDOWN.
//    IDLE:     sync=1 -> DEBOUNCE, cnt<=1.
//    DEBOUNCE: sync=0 -> IDLE (bounce rejected, no pulse). sync=1 and cnt<DEBOUNCE_CYCLES -> cnt+1.
//              sync=1 and cnt==DEBOUNCE_CYCLES -> HELD; pass<=~green_in; pass_count+1 iff pulse.
//    HELD:     wait for release; sync=0 -> COOLDOWN, cnt<=1.
//    COOLDOWN: cnt<COOLDOWN_CYCLES -> cnt+1; cnt==COOLDOWN_CYCLES -> IDLE.
//  - Latency: first edge sampling btn_raw=1 is edge 0; held steady, pass is 1 for exactly the cycle
//    following edge DEBOUNCE_CYCLES+2. pass is never high two consecutive cycles.
//  - Green suppression: press accepted while green_in=1 is consumed (HELD then COOLDOWN entered), no pulse.
//  - Button held indefinitely: exactly one pulse; no repeat until release plus full cooldown.
//  - Cooldown expiry with sync=1: goes IDLE; IDLE restarts debounce on the next cycle (fresh press).
//  - cnt saturates never; widths are sized by CNT_W, compare is equality on the terminal value.
// CONFIGURATION
//  Macro PASS_QUEUE_EN.
//  - Defined: any sync=1 sample in COOLDOWN sets pending. At cooldown expiry with pending=1:
//    clear pending, emit pass<=~green_in (pass_count+1 iff pulse), go HELD. The next cycle, HELD
//    exits to COOLDOWN if sync=0. pending is also cleared by rst.
//  - Not defined: presses during COOLDOWN are dropped, no pending register exists.
// STRUCTURE
//  - Shared package traffic_pkg: FSM state enum (2-bit), DEFAULT_DEBOUNCE=16, DEFAULT_COOLDOWN=2048.
//  - Sub-module btn_sync: 2-flop synchroniser with synchronous reset, 1-bit in/out.
//  - Top holds FSM, cnt, pending, pass/pass_count registers.
// TESTING (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
//  1 btn_raw=1 steady from edge 0, green_in=0 -> pass=1 only after edge 6, pass_count=1, busy=1.
//  2 btn_raw pulses 1,1,0,1,1,0 (bounce < 4 cycles) -> no pass, FSM returns IDLE, pass_count=0.
//  3 Valid press with green_in=1 -> no pass, pass_count=0, FSM still runs HELD->COOLDOWN->IDLE.
//  4 Second press 3 cycles into cooldown: no macro -> dropped, 1 pulse total;
//    PASS_QUEUE_EN -> second pulse on cooldown expiry, pass_count=2.
//  5 Button held 100 cycles -> exactly one pulse; release -> IDLE 8 cycles after COOLDOWN entry.
//  6 rst=1 for one cycle during DEBOUNCE (cnt=3) -> next cycle IDLE, pass=0, pass_count=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic light controller slice.
//   - state_e          : 2-bit FSM state encoding of the pass request conditioner
//   - DEFAULT_DEBOUNCE : default debounce length in clk cycles
//   - DEFAULT_COOLDOWN : default cooldown length in clk cycles
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  localparam int DEFAULT_DEBOUNCE = 16;
  localparam int DEFAULT_COOLDOWN = 2048;

endpackage

// File: rtl/btn_sync.sv
// btn_sync
//   Two-flop synchroniser bringing an asynchronous 1-bit input into the clk domain.
//   Ports:
//     clk  in  clock
//     rst  in  synchronous active-high reset, clears both flops
//     d    in  asynchronous input
//     q    out synchronised output (two clk cycles of latency)
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage metastability filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pass_request_conditioner.sv
// pass_request_conditioner
//   Turns the bouncy pedestrian button into a clean one-cycle pass request for the
//   traffic light controller: synchronise, debounce, suppress while green, cooldown.
//   Optional build macro PASS_QUEUE_EN: a press seen during cooldown is remembered and
//   served as a pass request when the cooldown expires (default build drops it).
//   Ports:
//     clk         in   clock (shared with the controller)
//     rst         in   synchronous active-high reset
//     btn_raw     in   asynchronous raw pedestrian button
//     green_in    in   controller green output; an accepted press is absorbed when 1
//     pass        out  registered one-cycle pass request
//     busy        out  1 whenever the FSM is not IDLE (registered)
//     pass_count  out  number of pass pulses emitted, wraps 255 -> 0
module pass_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN,
  parameter int CNT_W           = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       green_in,
  output logic       pass,
  output logic       busy,
  output logic [7:0] pass_count
);

  localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] COOL_END = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync_s;
  state_e           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             pass_r, pass_next_s;
  logic             busy_r;
  logic [7:0]       count_r, count_next_s;
`ifdef PASS_QUEUE_EN
  logic             pending_r, pending_next_s;
`endif

  btn_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (sync_s)
  );

  // Next-state, counter, pass pulse and pass counter decisions.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    pass_next_s  = 1'b0;
    count_next_s = count_r;
`ifdef PASS_QUEUE_EN
    pending_next_s = pending_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (sync_s) begin
          state_next_s = ST_DEBOUNCE;
          cnt_next_s   = CNT_ONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (!sync_s) begin
          state_next_s = ST_IDLE;
        end else if (cnt_r == DEB_END) begin
          // Press accepted; while green it is consumed without a pulse.
          state_next_s = ST_HELD;
          pass_next_s  = ~green_in;
          if (!green_in) begin
            count_next_s = count_r + 8'd1;
          end else begin
            count_next_s = count_r;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!sync_s) begin
          state_next_s = ST_COOLDOWN;
          cnt_next_s   = CNT_ONE;
        end else begin
          state_next_s = ST_HELD;
        end
      end
      ST_COOLDOWN: begin
`ifdef PASS_QUEUE_EN
        if (sync_s) begin
          pending_next_s = 1'b1;
        end else begin
          pending_next_s = pending_r;
        end
`endif
        if (cnt_r == COOL_END) begin
`ifdef PASS_QUEUE_EN
          // A press seen at any point of the cooldown, including this last sample, is served now.
          if (pending_r || sync_s) begin
            pending_next_s = 1'b0;
            state_next_s   = ST_HELD;
            pass_next_s    = ~green_in;
            if (!green_in) begin
              count_next_s = count_r + 8'd1;
            end else begin
              count_next_s = count_r;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
`else
          state_next_s = ST_IDLE;
`endif
          cnt_next_s = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; busy is registered from the next state so it tracks state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      pass_r  <= 1'b0;
      busy_r  <= 1'b0;
      count_r <= 8'd0;
`ifdef PASS_QUEUE_EN
      pending_r <= 1'b0;
`endif
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      pass_r  <= pass_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      count_r <= count_next_s;
`ifdef PASS_QUEUE_EN
      pending_r <= pending_next_s;
`endif
    end
  end

  assign pass       = pass_r;
  assign busy       = busy_r;
  assign pass_count = count_r;

endmodule

// File: tb/tb_pass_request_conditioner.sv
// Scoreboard bench for pass_request_conditioner with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8.
// The driver computes the expected outputs from a phase-counting reference model and queues
// them; the monitor pops one entry per clock and compares pass, busy and pass_count.
module tb_pass_request_conditioner;

  localparam int D = 4;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       green_in = 1'b0;
  logic       pass;
  logic       busy;
  logic [7:0] pass_count;

  pass_request_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .COOLDOWN_CYCLES (C),
    .CNT_W           (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .green_in   (green_in),
    .pass       (pass),
    .busy       (busy),
    .pass_count (pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       p;
    logic       b;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: delay line for the synchroniser, run length while debouncing,
  // a held flag, and remaining cooldown edges.
  int m_d1 = 0, m_d2 = 0;
  int m_run = 0, m_held = 0, m_cool = 0, m_pend = 0, m_cnt = 0;

  task automatic model_edge(input logic b, input logic g, input logic r);
    int s;
    int pulse;
    exp_t e;
    pulse = 0;
    if (r) begin
      m_d1 = 0; m_d2 = 0; m_run = 0; m_held = 0; m_cool = 0; m_pend = 0; m_cnt = 0;
    end else begin
      s = m_d2;
      m_d2 = m_d1;
      m_d1 = int'(b);
      if (m_cool > 0) begin
`ifdef PASS_QUEUE_EN
        if (s != 0) m_pend = 1;
`endif
        if (m_cool == 1) begin
          m_cool = 0;
          if (m_pend != 0) begin
            m_pend = 0;
            m_held = 1;
            pulse  = g ? 0 : 1;
          end
        end else begin
          m_cool = m_cool - 1;
        end
      end else if (m_held != 0) begin
        if (s == 0) begin
          m_held = 0;
          m_cool = C;
        end
      end else if (m_run > 0) begin
        if (s == 0) begin
          m_run = 0;
        end else if (m_run == D) begin
          m_run  = 0;
          m_held = 1;
          pulse  = g ? 0 : 1;
        end else begin
          m_run = m_run + 1;
        end
      end else if (s != 0) begin
        m_run = 1;
      end
      if (pulse != 0) m_cnt = (m_cnt + 1) % 256;
    end
    e.p = (pulse != 0);
    e.b = (m_run > 0) || (m_held != 0) || (m_cool > 0);
    e.c = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic b, input logic g, input logic r);
    @(negedge clk);
    btn_raw  = b;
    green_in = g;
    rst      = r;
    model_edge(b, g, r);
    @(posedge clk);
  endtask

  task automatic hold(input logic b, input logic g, input int n);
    for (int i = 0; i < n; i++) step(b, g, 1'b0);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, want);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pass", int'(pass), int'(mon_e.p));
      check("busy", int'(busy), int'(mon_e.b));
      check("pass_count", int'(pass_count), int'(mon_e.c));
    end
  end

  initial begin
    logic lvl;
    logic grn;
    int   len;
    // Reset state.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    hold(1'b0, 1'b0, 3);
    // Steady press with green off.
    hold(1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 14);
    // Bounce shorter than the debounce window.
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 6);
    // Press while green is absorbed.
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 14);
    // Second press a few cycles into the cooldown.
    hold(1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 16);
    // Button held for a long time, then released.
    hold(1'b1, 1'b0, 100);
    hold(1'b0, 1'b0, 14);
    // Reset in the middle of debouncing.
    hold(1'b1, 1'b0, 5);
    step(1'b1, 1'b0, 1'b1);
    hold(1'b0, 1'b0, 6);
    // Randomised button levels, green changes and occasional resets.
    grn = 1'b0;
    for (int k = 0; k < 400; k++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 7) == 0) grn = ~grn;
      for (int j = 0; j < len; j++) begin
        step(lvl, grn, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end
    end
    hold(1'b0, 1'b0, 20);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
